// File: rtl/gpr_bus_ctrl.sv
// Control sequencer for a GPR bank on shared A/B/C buses: read two sources,
// hand operands to execute, wait for the result, optionally write it back.
module gpr_bus_ctrl #(
  parameter int NREG  = 16,
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  req_rs_a,
  input  logic [IDX_W-1:0]  req_rs_b,
  input  logic [IDX_W-1:0]  req_rd,
  input  logic              req_wb,
  input  logic              req_thru,
  output logic [NREG-1:0]   rd_A_en,
  output logic [NREG-1:0]   rd_B_en,
  output logic [NREG-1:0]   wt_en,
  output logic [NREG-1:0]   through_C_en,
  output logic [31:0]       wdata,
  input  logic [31:0]       bus_A_in,
  input  logic [31:0]       bus_B_in,
  output logic              op_valid,
  output logic [31:0]       op_a,
  output logic [31:0]       op_b,
  input  logic              res_valid,
  input  logic [31:0]       res_data
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rs_a_q, rs_b_q, rd_q;
  logic [IDX_W-1:0]   rs_a_nxt, rs_b_nxt, rd_nxt;
  logic               wb_q, thru_q, wb_nxt, thru_nxt;
  logic [NREG-1:0]    rd_a_en_nxt, rd_b_en_nxt, wt_en_nxt, thru_en_nxt;
  logic               op_valid_nxt;
  logic [DATA_W-1:0]  op_a_nxt, op_b_nxt, wdata_nxt;

  // Indices at or above NREG decode to an all-zero vector.
  function automatic logic [NREG-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) v[i] = (int'(idx) == i);
    return v;
  endfunction

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return int'(idx) < NREG;
  endfunction

  assign req_ready = (state == IDLE);

  // Enables are computed one cycle ahead so that every enable leaves a flop.
  always_comb begin
    state_nxt    = state;
    rs_a_nxt     = rs_a_q;
    rs_b_nxt     = rs_b_q;
    rd_nxt       = rd_q;
    wb_nxt       = wb_q;
    thru_nxt     = thru_q;
    rd_a_en_nxt  = '0;
    rd_b_en_nxt  = '0;
    wt_en_nxt    = '0;
    thru_en_nxt  = '0;
    op_valid_nxt = op_valid;
    op_a_nxt     = op_a;
    op_b_nxt     = op_b;
    wdata_nxt    = wdata;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          rs_a_nxt    = req_rs_a;
          rs_b_nxt    = req_rs_b;
          rd_nxt      = req_rd;
          wb_nxt      = req_wb;
          thru_nxt    = req_thru;
          rd_a_en_nxt = idx_onehot(req_rs_a);
          rd_b_en_nxt = idx_onehot(req_rs_b);
          state_nxt   = READ;
        end
      end
      READ: begin
        op_a_nxt     = idx_in_range(rs_a_q) ? bus_A_in : '0;
        op_b_nxt     = idx_in_range(rs_b_q) ? bus_B_in : '0;
        op_valid_nxt = 1'b1;
        state_nxt    = EXEC;
      end
      EXEC: begin
        if (res_valid) begin
          op_valid_nxt = 1'b0;
          if (wb_q) begin
            wdata_nxt   = res_data;
            wt_en_nxt   = idx_onehot(rd_q);
            thru_en_nxt = thru_q ? idx_onehot(rd_q) : '0;
            state_nxt   = WRITE;
          end else begin
            state_nxt   = IDLE;
          end
        end
      end
      WRITE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Asynchronous reset drops every enable at once, so a write cannot complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rs_a_q       <= '0;
      rs_b_q       <= '0;
      rd_q         <= '0;
      wb_q         <= 1'b0;
      thru_q       <= 1'b0;
      rd_A_en      <= '0;
      rd_B_en      <= '0;
      wt_en        <= '0;
      through_C_en <= '0;
      op_valid     <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      wdata        <= '0;
    end else begin
      state        <= state_nxt;
      rs_a_q       <= rs_a_nxt;
      rs_b_q       <= rs_b_nxt;
      rd_q         <= rd_nxt;
      wb_q         <= wb_nxt;
      thru_q       <= thru_nxt;
      rd_A_en      <= rd_a_en_nxt;
      rd_B_en      <= rd_b_en_nxt;
      wt_en        <= wt_en_nxt;
      through_C_en <= thru_en_nxt;
      op_valid     <= op_valid_nxt;
      op_a         <= op_a_nxt;
      op_b         <= op_b_nxt;
      wdata        <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_gpr_bus_ctrl.sv
// Scoreboard bench for gpr_bus_ctrl with a 12-entry register bank model.
module tb_gpr_bus_ctrl;

  localparam int NREG  = 12;
  localparam int IDX_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready;
  logic [IDX_W-1:0]  req_rs_a, req_rs_b, req_rd;
  logic              req_wb, req_thru;
  logic [NREG-1:0]   rd_A_en, rd_B_en, wt_en, through_C_en;
  logic [31:0]       wdata, bus_A_in, bus_B_in, op_a, op_b, res_data;
  logic              op_valid, res_valid;

  gpr_bus_ctrl #(.NREG(NREG), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs_a(req_rs_a), .req_rs_b(req_rs_b), .req_rd(req_rd),
    .req_wb(req_wb), .req_thru(req_thru),
    .rd_A_en(rd_A_en), .rd_B_en(rd_B_en), .wt_en(wt_en),
    .through_C_en(through_C_en), .wdata(wdata),
    .bus_A_in(bus_A_in), .bus_B_in(bus_B_in),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // Register bank model: drives A/B/C from the enables, writes on wt_en.
  logic [31:0] bank [NREG];
  logic [31:0] bus_c;

  initial begin
    for (int i = 0; i < NREG; i++) bank[i] = 32'h100 + i;
    bank[2] = 32'h11; bank[5] = 32'h22; bank[3] = 32'h5A; bank[4] = 32'h99;
    forever begin
      @(posedge clk);
      for (int i = 0; i < NREG; i++)
        if (wt_en[i] && !through_C_en[i]) bank[i] <= wdata;
    end
  end

  always_comb begin
    bus_A_in = 32'hDEAD_BEEF;
    bus_B_in = 32'hDEAD_BEEF;
    bus_c    = 32'h0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_A_en[i]) bus_A_in = bank[i];
      if (rd_B_en[i]) bus_B_in = bank[i];
      if (through_C_en[i]) bus_c = bank[i];
      else if (wt_en[i])   bus_c = wdata;
    end
  end

  typedef struct {
    logic [31:0] rda, rdb, opa, opb, wt, thr, wd, c;
    int          opcyc;
    bit          wb, thru;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  int   mst = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic finish_bench();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
    finish_bench();
  endtask

  function automatic exp_t mk(input logic [31:0] rda, rdb, opa, opb, input int opcyc,
                              input bit wb, thru, input logic [31:0] wt, thr, wd, c);
    exp_t e;
    e.rda = rda; e.rdb = rdb; e.opa = opa; e.opb = opb; e.opcyc = opcyc;
    e.wb = wb; e.thru = thru; e.wt = wt; e.thr = thr; e.wd = wd; e.c = c;
    return e;
  endfunction

  // Monitor: follows each transaction from op_valid onward, popping the scoreboard.
  initial begin
    exp_t        e;
    int          cyc;
    logic [31:0] prev_rda, prev_rdb;
    prev_rda = '0;
    prev_rdb = '0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        mst = 0;
      end else begin
        case (mst)
          0: if (op_valid) begin
            if (sb.size() == 0) begin
              chk("unexpected_op_valid", 32'(sb.size()), 32'd1);
            end else begin
              e = sb.pop_front();
              chk("rd_A_en", prev_rda, e.rda);
              chk("rd_B_en", prev_rdb, e.rdb);
              chk("rd_en_one_cycle", 32'(rd_A_en | rd_B_en), 32'h0);
              chk("op_a", op_a, e.opa);
              chk("op_b", op_b, e.opb);
              cyc = 1;
              mst = 1;
            end
          end
          1: if (op_valid) begin
            cyc++;
            chk("op_a_hold", op_a, e.opa);
            chk("op_b_hold", op_b, e.opb);
          end else begin
            chk("op_valid_cycles", 32'(cyc), 32'(e.opcyc));
            if (e.wb) begin
              chk("wt_en", 32'(wt_en), e.wt);
              chk("through_C_en", 32'(through_C_en), e.thr);
              chk("wdata", wdata, e.wd);
              chk("ready_in_write", 32'(req_ready), 32'd0);
              if (e.thru) chk("bus_c", bus_c, e.c);
              mst = 2;
            end else begin
              chk("ready_after_exec", 32'(req_ready), 32'd1);
              chk("wt_en_no_wb", 32'(wt_en | through_C_en), 32'h0);
              mst = 0;
            end
          end
          2: begin
            chk("ready_after_write", 32'(req_ready), 32'd1);
            chk("wt_en_after_write", 32'(wt_en | through_C_en), 32'h0);
            mst = 0;
          end
          default: mst = 0;
        endcase
      end
      prev_rda = 32'(rd_A_en);
      prev_rdb = 32'(rd_B_en);
    end
  end

  task automatic do_req(input int rsa, rsb, rd, input bit wb, thru, input int lat,
                        input logic [31:0] res, input bit pulse_res_read,
                        input bit pulse_req_exec, input bit push, input exp_t e);
    int n;
    n = 0;
    while (!req_ready) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) timeout("wait_req_ready");
    end
    if (push) sb.push_back(e);
    req_valid = 1'b1;
    req_rs_a = IDX_W'(rsa); req_rs_b = IDX_W'(rsb); req_rd = IDX_W'(rd);
    req_wb = wb; req_thru = thru;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_rs_a = '1; req_rs_b = '1; req_rd = '1; req_wb = 1'b0; req_thru = 1'b0;
    if (pulse_res_read) begin
      res_valid = 1'b1;
      res_data  = 32'hFFFF;
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
    n = 0;
    while (!op_valid) begin
      @(posedge clk); #1;
      n++;
      if (n > 20) timeout("wait_op_valid");
    end
    for (int k = 0; k < lat; k++) begin
      if (pulse_req_exec && k == 0) begin
        req_valid = 1'b1;
        req_rs_a = '0; req_rs_b = '0; req_rd = '0; req_wb = 1'b0;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    res_valid = 1'b1;
    res_data  = res;
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  initial begin
    int n;
    // Reset with random inputs
    rst_n     = 1'b0;
    req_valid = 1'($urandom);
    req_rs_a  = IDX_W'($urandom);
    req_rs_b  = IDX_W'($urandom);
    req_rd    = IDX_W'($urandom);
    req_wb    = 1'($urandom);
    req_thru  = 1'($urandom);
    res_valid = 1'($urandom);
    res_data  = $urandom;
    #3;
    chk("rst_enables", 32'(rd_A_en | rd_B_en | wt_en | through_C_en), 32'h0);
    chk("rst_op_valid", 32'(op_valid), 32'd0);
    chk("rst_op_a", op_a, 32'h0);
    chk("rst_op_b", op_b, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_enables", 32'(rd_A_en | rd_B_en | wt_en | through_C_en), 32'h0);
    chk("rst_hold_op_valid", 32'(op_valid), 32'd0);
    chk("rst_hold_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0; res_valid = 1'b0; res_data = '0;
    req_wb = 1'b0; req_thru = 1'b0;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Basic writeback
    do_req(2, 5, 7, 1'b1, 1'b0, 0, 32'hABCD, 1'b0, 1'b0, 1'b1,
           mk(32'h004, 32'h020, 32'h11, 32'h22, 1, 1'b1, 1'b0, 32'h080, 32'h0, 32'hABCD, 32'h0));
    // Shared source, no writeback, result three cycles late
    do_req(3, 3, 1, 1'b0, 1'b0, 3, 32'h777, 1'b0, 1'b0, 1'b1,
           mk(32'h008, 32'h008, 32'h5A, 32'h5A, 4, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0));
    // C-through on r4
    do_req(0, 1, 4, 1'b1, 1'b1, 0, 32'h1234, 1'b0, 1'b0, 1'b1,
           mk(32'h001, 32'h002, 32'h100, 32'h101, 1, 1'b1, 1'b1, 32'h010, 32'h010, 32'h1234, 32'h99));
    // Out-of-range source plus ignored res_valid in READ and req_valid in EXEC
    do_req(13, 6, 9, 1'b1, 1'b0, 2, 32'hCAFE, 1'b1, 1'b1, 1'b1,
           mk(32'h0, 32'h040, 32'h0, 32'h106, 3, 1'b1, 1'b0, 32'h200, 32'h0, 32'hCAFE, 32'h0));
    // Out-of-range everywhere: WRITE still takes its cycle with no enable
    do_req(12, 15, 14, 1'b1, 1'b0, 0, 32'h55, 1'b0, 1'b0, 1'b1,
           mk(32'h0, 32'h0, 32'h0, 32'h0, 1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h55, 32'h0));
    repeat (3) @(posedge clk);
    #1;
    chk("bank_r7", bank[7], 32'hABCD);
    chk("bank_r1", bank[1], 32'h101);
    chk("bank_r4_thru", bank[4], 32'h99);
    chk("bank_r9", bank[9], 32'hCAFE);

    // Reset dropped in the middle of WRITE
    mon_en = 1'b0;
    do_req(2, 5, 6, 1'b1, 1'b0, 0, 32'hBAD, 1'b0, 1'b0, 1'b0, sb.size() > 0 ? sb[0] :
           mk(32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0));
    chk("abort_wt_en_before", 32'(wt_en), 32'h040);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_wt_en_async", 32'(wt_en | through_C_en), 32'h0);
    @(posedge clk); #1;
    chk("abort_bank_r6", bank[6], 32'h106);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_op_valid", 32'(op_valid), 32'd0);
    chk("abort_op_a", op_a, 32'h0);
    chk("abort_op_b", op_b, 32'h0);
    chk("abort_wdata", wdata, 32'h0);
    chk("abort_ready_after", 32'(req_ready), 32'd1);
    mon_en = 1'b1;

    // New request after reset
    do_req(7, 9, 0, 1'b1, 1'b0, 1, 32'h3141, 1'b0, 1'b0, 1'b1,
           mk(32'h080, 32'h200, 32'hABCD, 32'hCAFE, 2, 1'b1, 1'b0, 32'h001, 32'h0, 32'h3141, 32'h0));
    n = 0;
    while (sb.size() != 0 || mst != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 20) timeout("wait_scoreboard_drain");
    end
    @(posedge clk); #1;
    chk("bank_r0", bank[0], 32'h3141);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    finish_bench();
  end

endmodule
